// File: rtl/generador_tablero_if.sv
// Board-generator bus: start request, protected cell, read port and status.
// master = game controller / display side, slave = generador_tablero.
interface generador_tablero_if;
  logic       start;
  logic [3:0] safe_fila;
  logic [3:0] safe_col;
  logic [3:0] rd_fila;
  logic [3:0] rd_col;
  logic       rd_bomba;
  logic [3:0] rd_vecinos;
  logic       busy;
  logic       tablero_generado;

  modport master (
    output start, safe_fila, safe_col, rd_fila, rd_col,
    input  rd_bomba, rd_vecinos, busy, tablero_generado
  );

  modport slave (
    input  start, safe_fila, safe_col, rd_fila, rd_col,
    output rd_bomba, rd_vecinos, busy, tablero_generado
  );
endinterface

// File: rtl/generador_tablero.sv
// Minesweeper board generator: clear, LFSR mine placement avoiding the first-click
// cell, then a row-major neighbour-count scan. Registers update on the falling edge.
module generador_tablero #(
  parameter int          FILAS     = 8,
  parameter int          COLS      = 8,
  parameter int          NUM_MINAS = 10,
  parameter logic [15:0] SEMILLA   = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  generador_tablero_if.slave bus
);
  localparam int FW = (FILAS > 1) ? $clog2(FILAS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int MW = $clog2(FILAS * COLS + 1);

  if (FILAS < 2 || FILAS > 16 || COLS < 2 || COLS > 16) begin : g_err_dim
    $error("generador_tablero: FILAS/COLS must be in 2..16");
  end
  if (NUM_MINAS < 0 || NUM_MINAS > FILAS * COLS - 1) begin : g_err_minas
    $error("generador_tablero: NUM_MINAS must be in 0..FILAS*COLS-1");
  end
  if (SEMILLA == 16'h0000) begin : g_err_semilla
    $error("generador_tablero: SEMILLA must be non-zero");
  end

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_PLACE, S_COUNT, S_DONE} estado_t;

  estado_t                         r_estado, w_sig;
  logic [15:0]                     r_lfsr;
  logic [FILAS-1:0][COLS-1:0]      r_bomba;
  logic [FILAS-1:0][COLS-1:0][3:0] r_vec;
  logic [MW-1:0]                   r_minas;
  logic [FW-1:0]                   r_scan_f;
  logic [CW-1:0]                   r_scan_c;
  logic [3:0]                      r_safe_f, r_safe_c;

  logic [3:0] w_cand_f, w_cand_c;
  logic       w_cand_ok, w_lleno, w_ultimo;
  logic [3:0] w_suma;

  assign w_cand_f = r_lfsr[3:0];
  assign w_cand_c = r_lfsr[7:4];
  assign w_lleno  = (r_minas == MW'(NUM_MINAS));
  assign w_ultimo = (r_scan_f == FW'(FILAS - 1)) && (r_scan_c == CW'(COLS - 1));

  always_comb begin
    w_cand_ok = 1'b0;
    if (int'(w_cand_f) < FILAS && int'(w_cand_c) < COLS)
      w_cand_ok = !r_bomba[FW'(w_cand_f)][CW'(w_cand_c)] &&
                  !(w_cand_f == r_safe_f && w_cand_c == r_safe_c);
  end

  // 3x3 window around the scan cell; out-of-board neighbours simply don't exist
  always_comb begin
    int nf, nc;
    nf     = 0;
    nc     = 0;
    w_suma = '0;
    for (int df = -1; df <= 1; df++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nf = int'(r_scan_f) + df;
        nc = int'(r_scan_c) + dc;
        if ((df != 0 || dc != 0) && nf >= 0 && nf < FILAS && nc >= 0 && nc < COLS)
          w_suma = w_suma + 4'(r_bomba[FW'(nf)][CW'(nc)]);
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) r_estado <= S_IDLE;
    else     r_estado <= w_sig;
  end

  always_comb begin
    w_sig = r_estado;
    case (r_estado)
      S_IDLE:  if (bus.start) w_sig = S_CLEAR;
      S_CLEAR: w_sig = S_PLACE;
      S_PLACE: if (w_lleno) w_sig = S_COUNT;
      S_COUNT: if (w_ultimo) w_sig = S_DONE;
      S_DONE:  if (!bus.start) w_sig = S_IDLE;
      default: w_sig = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr   <= SEMILLA;
      r_bomba  <= '0;
      r_vec    <= '0;
      r_minas  <= '0;
      r_scan_f <= '0;
      r_scan_c <= '0;
      r_safe_f <= '0;
      r_safe_c <= '0;
    end else begin
      // free-running, so the layout depends on when start arrives
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      case (r_estado)
        S_IDLE: begin
          if (bus.start) begin
            r_safe_f <= bus.safe_fila;
            r_safe_c <= bus.safe_col;
          end
        end
        S_CLEAR: begin
          r_bomba  <= '0;
          r_vec    <= '0;
          r_minas  <= '0;
          r_scan_f <= '0;
          r_scan_c <= '0;
        end
        S_PLACE: begin
          if (!w_lleno && w_cand_ok) begin
            r_bomba[FW'(w_cand_f)][CW'(w_cand_c)] <= 1'b1;
            r_minas <= r_minas + MW'(1);
          end
        end
        S_COUNT: begin
          r_vec[r_scan_f][r_scan_c] <= w_suma;
          if (r_scan_c == CW'(COLS - 1)) begin
            r_scan_c <= '0;
            r_scan_f <= r_scan_f + FW'(1);
          end else begin
            r_scan_c <= r_scan_c + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.rd_bomba   = 1'b0;
    bus.rd_vecinos = '0;
    if (int'(bus.rd_fila) < FILAS && int'(bus.rd_col) < COLS) begin
      bus.rd_bomba   = r_bomba[FW'(bus.rd_fila)][CW'(bus.rd_col)];
      bus.rd_vecinos = r_vec[FW'(bus.rd_fila)][CW'(bus.rd_col)];
    end
  end

  assign bus.busy             = (r_estado == S_CLEAR) || (r_estado == S_PLACE) ||
                                (r_estado == S_COUNT);
  assign bus.tablero_generado = (r_estado == S_DONE);
endmodule
